// File: rtl/spi_reg_decoder.sv
// -----------------------------------------------------------------------------
// spi_reg_decoder
// Consumes bytes from a first-word-fall-through RX FIFO, parses them into
// register-access packets (header, count, payload) and exposes a bank of
// NUM_REGS byte-wide control registers. Read packets push register values
// into a TX FIFO, one byte per cycle, honouring tx_full backpressure.
//
// Header byte : bit7 = write(1)/read(0), bit6 = auto-increment,
//               bits[ADDR_WIDTH-1:0] = start address, other bits ignored.
// Count byte  : number of data bytes (0..255). Only writes carry payload.
//
// Optional build macro: SPI_DECODER_TIMEOUT_EN
//   Defined   -> an idle counter aborts a stalled packet after TIMEOUT_CYCLES
//                cycles without RX data in S_COUNT/S_WDATA and sets the
//                sticky pkt_error flag.
//   Undefined -> no counter; the block waits indefinitely and pkt_error is 0.
// -----------------------------------------------------------------------------
module spi_reg_decoder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          rx_data,
    input  logic                           rx_empty,
    output logic                           rx_pop,
    output logic [DATA_WIDTH-1:0]          tx_data,
    output logic                           tx_valid,
    input  logic                           tx_full,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_strobe,
    output logic                           busy,
    output logic                           pkt_done,
    output logic                           pkt_error
);

    // Elaboration-time guards on the parameter set.
    if (DATA_WIDTH != 8) begin : g_chk_data_width
        $error("spi_reg_decoder: DATA_WIDTH must be 8");
    end
    if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 6) || (NUM_REGS != (32'd1 << ADDR_WIDTH))) begin : g_chk_addr
        $error("spi_reg_decoder: NUM_REGS must equal 2**ADDR_WIDTH with 1 <= ADDR_WIDTH <= 6");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_chk_timeout
        $error("spi_reg_decoder: TIMEOUT_CYCLES must be non-zero");
    end

    localparam int unsigned HDR_RW_BIT  = 7;
    localparam int unsigned HDR_INC_BIT = 6;

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_COUNT  = 2'd1,
        S_WDATA  = 2'd2,
        S_RDATA  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_rw;
    logic                    r_inc;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_remaining;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_valid;
    logic [NUM_REGS-1:0]     r_wr_strobe;
    logic                    r_pkt_done;

    logic                    w_accepting;
    logic                    w_pop;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic                    w_last_byte;
    logic                    w_timeout;

    // A byte is consumed only in states that expect RX data, and never while
    // reset is asserted, so the FIFO is not drained during reset.
    assign w_accepting = (r_state == S_HEADER) || (r_state == S_COUNT) || (r_state == S_WDATA);
    assign w_pop       = w_accepting && !rx_empty && reset;
    assign rx_pop      = w_pop;

    // Address width equals log2(NUM_REGS), so the natural overflow of the
    // increment implements the NUM_REGS-1 -> 0 wrap.
    assign w_next_addr = r_inc ? (r_addr + ADDR_WIDTH'(1)) : r_addr;
    assign w_last_byte = (r_remaining == 8'd1);

`ifdef SPI_DECODER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_idle_cnt;
    logic            r_pkt_error;
    logic            w_idle_wait;

    // Only waits for RX data are timed; tx_full stalls in S_RDATA are not.
    assign w_idle_wait = ((r_state == S_COUNT) || (r_state == S_WDATA)) && rx_empty;
    assign w_timeout   = w_idle_wait && (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: counts starved cycles mid-packet, clears on any other cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idle_cnt  <= '0;
            r_pkt_error <= 1'b0;
        end else if (w_timeout) begin
            r_idle_cnt  <= '0;
            r_pkt_error <= 1'b1;
        end else if (w_idle_wait) begin
            r_idle_cnt  <= r_idle_cnt + TO_W'(1);
        end else begin
            r_idle_cnt  <= '0;
        end
    end

    assign pkt_error = r_pkt_error;
`else
    assign w_timeout = 1'b0;
    assign pkt_error = 1'b0;
`endif

    // Packet parser, register bank and registered output pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_HEADER;
            r_rw        <= 1'b0;
            r_inc       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_wr_strobe <= '0;
            r_pkt_done  <= 1'b0;
            // NOTE: the bank must read as all-zero after reset, so it is built
            // from flops cleared here rather than from a RAM, which cannot be
            // cleared in one cycle.
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // NOTE: pulse outputs default low every cycle; the non-blocking
            // assignments below override them only in the cycle that fires,
            // and the last non-blocking write to a flop in a block wins.
            r_tx_valid  <= 1'b0;
            r_wr_strobe <= '0;
            r_pkt_done  <= 1'b0;

            case (r_state)
                S_HEADER: begin
                    if (w_pop) begin
                        r_rw    <= rx_data[HDR_RW_BIT];
                        r_inc   <= rx_data[HDR_INC_BIT];
                        r_addr  <= rx_data[ADDR_WIDTH-1:0];
                        r_state <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (w_pop) begin
                        r_remaining <= rx_data;
                        if (rx_data == '0) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= S_HEADER;
                        end else begin
                            r_state <= r_rw ? S_WDATA : S_RDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (w_pop) begin
                        r_regs[r_addr] <= rx_data;
                        r_wr_strobe    <= NUM_REGS'(1) << r_addr;
                        r_addr         <= w_next_addr;
                        r_remaining    <= r_remaining - 8'd1;
                        if (w_last_byte) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= S_HEADER;
                        end
                    end
                end

                S_RDATA: begin
                    if (!tx_full) begin
                        r_tx_data   <= r_regs[r_addr];
                        r_tx_valid  <= 1'b1;
                        r_addr      <= w_next_addr;
                        r_remaining <= r_remaining - 8'd1;
                        if (w_last_byte) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= S_HEADER;
                        end
                    end
                end

                default: r_state <= S_HEADER;
            endcase

            // A timeout only fires while starved, so no pop or pkt_done can
            // coincide with it; it simply returns the parser to the header.
            if (w_timeout) begin
                r_state <= S_HEADER;
            end
        end
    end

    // Flatten the bank: register i occupies bits [i*8+7:i*8].
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign reg_wr_strobe = r_wr_strobe;
    assign pkt_done      = r_pkt_done;
    assign busy          = (r_state != S_HEADER);

endmodule

// File: tb/tb_spi_reg_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_decoder
// Directed packets from the block's test plan followed by randomized packets
// with random RX gaps and TX backpressure. A packet-level model (array of
// register values plus expected strobe/read-back lists) supplies every
// expected value. Timeout checks are compiled in with SPI_DECODER_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_spi_reg_decoder;

    localparam int NR = 16;
    localparam int RW = NR * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic          rx_pop;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_full;
    logic [RW-1:0] reg_out;
    logic [NR-1:0] reg_wr_strobe;
    logic          busy;
    logic          pkt_done;
    logic          pkt_error;

    spi_reg_decoder #(
        .DATA_WIDTH    (8),
        .NUM_REGS      (NR),
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_pop       (rx_pop),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_full      (tx_full),
        .reg_out      (reg_out),
        .reg_wr_strobe(reg_wr_strobe),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .pkt_error    (pkt_error)
    );

    always #5 clk = ~clk;

    // Bench state: RX FIFO contents, observed logs and model expectations.
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    int         st_addr[$];
    logic [7:0] st_val[$];
    int         done_cnt;
    int         viol;
    logic [7:0] m_regs [NR];
    int         exp_st_addr[$];
    logic [7:0] exp_st_val[$];
    logic [7:0] exp_tx[$];
    logic       drv_reset  = 1'b0;
    logic       rand_gap   = 1'b0;
    logic       rand_full  = 1'b0;
    logic       full_mid   = 1'b0;
    int         full_hold  = 0;
    logic       prev_full  = 1'b0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] flat_model();
        logic [RW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    // One clock: drive inputs at the falling edge, sample just before the
    // rising edge, and log everything the DUT presented in that cycle.
    task automatic cycle();
        @(negedge clk);
        reset = drv_reset;
        if (rxq.size() != 0) begin
            rx_data  = rxq[0];
            rx_empty = rand_gap && ($urandom_range(0, 3) == 0);
        end else begin
            rx_data  = 8'h00;
            rx_empty = 1'b1;
        end
        if (full_hold > 0) begin
            tx_full = 1'b1;
            full_hold--;
        end else begin
            tx_full = rand_full && ($urandom_range(0, 2) == 0);
        end
        #4;
        if (rx_pop === 1'b1) begin
            if (rx_empty) viol++;
            void'(rxq.pop_front());
        end
        if (tx_valid === 1'b1) begin
            if (prev_full) viol++;
            tx_log.push_back(tx_data);
            if (full_mid) begin
                full_hold = 5;
                full_mid  = 1'b0;
            end
        end
        if ((reg_wr_strobe !== '0) && !$isunknown(reg_wr_strobe)) begin
            if (!$onehot(reg_wr_strobe)) viol++;
            for (int i = 0; i < NR; i++) begin
                if (reg_wr_strobe[i]) begin
                    st_addr.push_back(i);
                    st_val.push_back(reg_out[i*8 +: 8]);
                end
            end
        end
        if (pkt_done === 1'b1) done_cnt++;
        prev_full = tx_full;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        st_addr.delete();
        st_val.delete();
        done_cnt = 0;
        viol     = 0;
    endtask

    // Packet-level reference: walk the addresses the packet touches.
    task automatic model_pkt(input logic [7:0] h, input logic [7:0] c, input logic [7:0] pl[$]);
        int a;
        exp_st_addr.delete();
        exp_st_val.delete();
        exp_tx.delete();
        a = int'(h) % NR;
        for (int k = 0; k < int'(c); k++) begin
            if (h[7]) begin
                m_regs[a] = pl[k];
                exp_st_addr.push_back(a);
                exp_st_val.push_back(pl[k]);
            end else begin
                exp_tx.push_back(m_regs[a]);
            end
            if (h[6]) a = (a + 1) % NR;
        end
    endtask

    task automatic push_pkt(input logic [7:0] h, input logic [7:0] c, input logic [7:0] pl[$]);
        rxq.push_back(h);
        rxq.push_back(c);
        if (h[7]) begin
            for (int k = 0; k < int'(c); k++) rxq.push_back(pl[k]);
        end
    endtask

    // Run until the packet is consumed and finished, then compare the logs.
    task automatic finish_pkt(input string tag);
        int n;
        int m;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!((rxq.size() == 0) && (busy === 1'b0)) && (n < 3000));
        check({tag, " completes"}, RW'(n < 3000), RW'(1));
        cycle();
        check({tag, " pkt_done"}, RW'(done_cnt), RW'(1));
        check({tag, " strobes"}, RW'(st_addr.size()), RW'(exp_st_addr.size()));
        m = (st_addr.size() < exp_st_addr.size()) ? st_addr.size() : exp_st_addr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s strobe%0d addr", tag, i), RW'(st_addr[i]), RW'(exp_st_addr[i]));
            check($sformatf("%s strobe%0d data", tag, i), RW'(st_val[i]), RW'(exp_st_val[i]));
        end
        check({tag, " tx bytes"}, RW'(tx_log.size()), RW'(exp_tx.size()));
        m = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s tx%0d", tag, i), RW'(tx_log[i]), RW'(exp_tx[i]));
        end
        check({tag, " reg_out"}, reg_out, flat_model());
        check({tag, " busy idle"}, RW'(busy), RW'(0));
        check({tag, " protocol"}, RW'(viol), RW'(0));
    endtask

    task automatic run_pkt(input string tag, input logic [7:0] h, input logic [7:0] c, input logic [7:0] pl[$]);
        clear_logs();
        model_pkt(h, c, pl);
        push_pkt(h, c, pl);
        finish_pkt(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " reg_out"}, reg_out, RW'(0));
        check({tag, " busy"}, RW'(busy), RW'(0));
        check({tag, " tx_valid"}, RW'(tx_valid), RW'(0));
        check({tag, " tx_data"}, RW'(tx_data), RW'(0));
        check({tag, " strobe"}, RW'(reg_wr_strobe), RW'(0));
        check({tag, " pkt_done"}, RW'(pkt_done), RW'(0));
        check({tag, " pkt_error"}, RW'(pkt_error), RW'(0));
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] h;
        logic [7:0] c;
        int         n;

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_empty = 1'b1;
        tx_full  = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;

        // Reset state.
        drv_reset = 1'b0;
        repeat (3) cycle();
        check_reset_state("reset");
        check("reset rx_pop", RW'(rx_pop), RW'(0));
        drv_reset = 1'b1;
        cycle();

        // Single write.
        pl = {8'hA5};
        run_pkt("write single", 8'h83, 8'h01, pl);

        // Burst write wrapping 15 -> 0.
        pl = {8'h11, 8'h22, 8'h33};
        run_pkt("write wrap", 8'hCE, 8'h03, pl);

        // Read burst with tx_full held for 5 cycles after the first push.
        pl.delete();
        full_mid = 1'b1;
        run_pkt("read backpressure", 8'h4E, 8'h03, pl);

        // Zero count, then repeated writes to one address.
        pl.delete();
        run_pkt("zero count", 8'h85, 8'h00, pl);
        pl = {8'h10, 8'h20};
        run_pkt("repeat write", 8'h85, 8'h02, pl);

        // Read-back of everything written so far, fixed address.
        pl.delete();
        run_pkt("read fixed", 8'h05, 8'h02, pl);

        // Reset mid-packet after a header has been consumed.
        clear_logs();
        rxq.push_back(8'h82);
        n = 0;
        while ((rxq.size() != 0) && (n < 50)) begin
            cycle();
            n++;
        end
        cycle();
        check("mid-packet busy", RW'(busy), RW'(1));
        pl = {8'h7F};
        push_pkt(8'h82, 8'h01, pl);
        drv_reset = 1'b0;
        cycle();
        check("reset blocks pop", RW'(rx_pop), RW'(0));
        drv_reset = 1'b1;
        cycle();
        check_reset_state("reset mid-packet");
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        model_pkt(8'h82, 8'h01, pl);
        finish_pkt("after reset");

`ifdef SPI_DECODER_TIMEOUT_EN
        // Starve a write packet: abort after exactly 16 idle cycles.
        clear_logs();
        pl = {8'h55};
        push_pkt(8'h81, 8'h02, pl);
        m_regs[1] = 8'h55;
        n = 0;
        while ((rxq.size() != 0) && (n < 50)) begin
            cycle();
            n++;
        end
        repeat (16) cycle();
        check("timeout not early busy", RW'(busy), RW'(1));
        check("timeout not early error", RW'(pkt_error), RW'(0));
        cycle();
        check("timeout abort busy", RW'(busy), RW'(0));
        check("timeout pkt_error", RW'(pkt_error), RW'(1));
        check("timeout no pkt_done", RW'(done_cnt), RW'(0));
        check("timeout reg_out", reg_out, flat_model());
        pl = {8'h66};
        run_pkt("after timeout", 8'h82, 8'h01, pl);
        check("pkt_error sticky", RW'(pkt_error), RW'(1));
`endif

        // Randomized packets with RX gaps and TX backpressure.
        rand_gap  = 1'b1;
        rand_full = 1'b1;
        for (int p = 0; p < 40; p++) begin
            h = 8'($urandom);
            if ($urandom_range(0, 7) == 0) c = 8'h00;
            else if ($urandom_range(0, 9) == 0) c = 8'($urandom_range(10, 24));
            else c = 8'($urandom_range(1, 6));
            pl.delete();
            for (int k = 0; k < int'(c); k++) pl.push_back(8'($urandom));
            run_pkt($sformatf("random%0d h=%02h c=%0d", p, h, c), h, c, pl);
        end

`ifndef SPI_DECODER_TIMEOUT_EN
        check("pkt_error tied low", RW'(pkt_error), RW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
